alu_issue_stage: RTL and testbench

// - ID/EX issue stage that drives the ALU: decodes RV32I instruction fields into the 4-bit ALU control

---
 rtl/alu_issue_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes a subset of RV32I into ALU control and operands,
// then queues the issued ops in a two-entry skid buffer toward EX.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_inp1,
  output logic [XLEN-1:0] alu_inp2,
  output logic [3:0]      alu_control,
  output logic [4:0]      rd_addr,
  output logic            reg_write,
  output logic [1:0]      mem_op,
  output logic            illegal
);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] inp1;
    logic [XLEN-1:0] inp2;
    logic [3:0]      ctrl;
    logic [4:0]      rd;
    logic            rw;
    logic [1:0]      mem;
    logic            ill;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Flipping the MSB maps signed order onto unsigned order for the ALU compare.
  function automatic logic [XLEN-1:0] sign_bias(input logic [XLEN-1:0] v);
    return v ^ {1'b1, {(XLEN-1){1'b0}}};
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] opnd_a;
  logic [XLEN-1:0] opnd_b;
  logic [3:0]      dec_ctrl;
  logic [1:0]      dec_mem;
  logic            dec_legal;
  logic            dec_writes;
  logic            dec_store;
  logic            dec_shift;
  logic            dec_signed;
  entry_t          dec;

  // rs1 index is resolved by the register file before this stage.
  logic unused_rs1_field;
  assign unused_rs1_field = ^instr[19:15];

  always_comb begin
    opcode     = instr[6:0];
    funct3     = instr[14:12];
    funct7     = instr[31:25];
    imm_i      = {{(XLEN-12){instr[31]}}, instr[31:20]};
    imm_s      = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    opnd_b     = rs2_data;
    dec_ctrl   = ALU_PASS;
    dec_mem    = MEM_NONE;
    dec_legal  = 1'b0;
    dec_writes = 1'b0;
    dec_store  = 1'b0;
    dec_shift  = 1'b0;
    dec_signed = 1'b0;
    unique case (opcode)
      OPC_R: begin
        opnd_b = rs2_data;
        if (funct7 == 7'b0000000) begin
          dec_legal = 1'b1;
          unique case (funct3)
            3'b000:  dec_ctrl = ALU_ADD;
            3'b001:  begin dec_ctrl = ALU_SLL;  dec_shift  = 1'b1; end
            3'b010:  begin dec_ctrl = ALU_SLTU; dec_signed = 1'b1; end
            3'b011:  dec_ctrl = ALU_SLTU;
            3'b100:  dec_ctrl = ALU_XOR;
            default: dec_legal = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec_ctrl  = ALU_SUB;
        end
        dec_writes = 1'b1;
      end
      OPC_I: begin
        opnd_b    = imm_i;
        dec_legal = 1'b1;
        unique case (funct3)
          3'b000:  dec_ctrl = ALU_ADD;
          3'b001:  begin
            dec_ctrl  = ALU_SLL;
            dec_shift = 1'b1;
            dec_legal = (funct7 == 7'b0000000);
          end
          3'b010:  begin dec_ctrl = ALU_SLTU; dec_signed = 1'b1; end
          3'b011:  dec_ctrl = ALU_SLTU;
          3'b100:  dec_ctrl = ALU_XOR;
          default: dec_legal = 1'b0;
        endcase
        dec_writes = 1'b1;
      end
      OPC_LOAD: begin
        opnd_b     = imm_i;
        dec_ctrl   = ALU_ADD;
        dec_mem    = MEM_LOAD;
        dec_legal  = (funct3 == 3'b010);
        dec_writes = 1'b1;
      end
      OPC_STORE: begin
        opnd_b    = imm_s;
        dec_ctrl  = ALU_ADD;
        dec_mem   = MEM_STORE;
        dec_store = 1'b1;
        dec_legal = (funct3 == 3'b010);
      end
      default: dec_legal = 1'b0;
    endcase

    opnd_a = rs1_data;
    if (dec_shift) opnd_b = {{(XLEN-5){1'b0}}, opnd_b[4:0]};
    if (dec_signed) begin
      opnd_a = sign_bias(opnd_a);
      opnd_b = sign_bias(opnd_b);
    end

    dec.inp1 = opnd_a;
    dec.inp2 = opnd_b;
    dec.ctrl = dec_legal ? dec_ctrl : ALU_PASS;
    dec.rd   = dec_store ? 5'd0 : instr[11:7];
    dec.rw   = dec_legal & dec_writes & (instr[11:7] != 5'd0);
    dec.mem  = dec_legal ? dec_mem : MEM_NONE;
    dec.ill  = ~dec_legal;
  end

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  logic   accept;
  logic   consume;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  // Buffer control; flush overrides both accept and consume.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = dec;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            head_d = dec;
          end else if (accept) begin
            tail_d  = dec;
            state_d = TWO;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            head_d  = tail_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign alu_inp1    = head_q.inp1;
  assign alu_inp2    = head_q.inp2;
  assign alu_control = head_q.ctrl;
  assign rd_addr     = head_q.rd;
  assign reg_write   = head_q.rw;
  assign mem_op      = head_q.mem;
  assign illegal     = head_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed vectors, expected entries
// queued at acceptance and checked by a monitor whenever EX takes the head.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_inp1;
  logic [31:0] alu_inp2;
  logic [3:0]  alu_control;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic [1:0]  mem_op;
  logic        illegal;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_control(alu_control),
    .rd_addr(rd_addr), .reg_write(reg_write), .mem_op(mem_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OPL = 7'b0000011;

  typedef struct {
    string       name;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [3:0]  c;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  mem;
    logic        ill;
    logic        ops;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   nvec = 0;
  int   nerr = 0;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic exp_t mk(input string n, input logic [31:0] i1, input logic [31:0] i2,
                              input logic [3:0] c, input logic [4:0] rd, input logic rw,
                              input logic [1:0] mem, input logic ill, input logic ops);
    exp_t e;
    e.name = n; e.i1 = i1; e.i2 = i2; e.c = c; e.rd = rd;
    e.rw = rw; e.mem = mem; e.ill = ill; e.ops = ops;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  // Present one op and hold it until the stage takes it.
  task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                      input exp_t e);
    bit done = 1'b0;
    in_valid = 1'b1; instr = ins; rs1_data = r1; rs2_data = r2;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(e);
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      nvec++; nerr++;
      $display("FAIL accept_%s: in_ready never returned, expected acceptance", e.name);
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({nm, "_in_ready"},  {31'b0, in_ready},  32'd1);
    chk({nm, "_inp1"},      alu_inp1,           32'd0);
    chk({nm, "_inp2"},      alu_inp2,           32'd0);
    chk({nm, "_ctrl"},      {28'b0, alu_control}, 32'd0);
    chk({nm, "_fields"},    {24'b0, rd_addr, reg_write, mem_op}, 32'd0);
    chk({nm, "_illegal"},   {31'b0, illegal},   32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      nvec++;
      if (sbq.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_out: got ctrl=%b inp1=%h, expected no valid output",
                 alu_control, alu_inp1);
      end else begin
        mon_e = sbq.pop_front();
        if ((mon_e.ops && (alu_inp1 !== mon_e.i1 || alu_inp2 !== mon_e.i2)) ||
            alu_control !== mon_e.c || rd_addr !== mon_e.rd || reg_write !== mon_e.rw ||
            mem_op !== mon_e.mem || illegal !== mon_e.ill) begin
          nerr++;
          $display("FAIL %s: got inp1=%h inp2=%h ctrl=%b rd=%0d rw=%b mem=%b ill=%b; expected inp1=%h inp2=%h ctrl=%b rd=%0d rw=%b mem=%b ill=%b",
                   mon_e.name, alu_inp1, alu_inp2, alu_control, rd_addr, reg_write, mem_op,
                   illegal, mon_e.i1, mon_e.i2, mon_e.c, mon_e.rd, mon_e.rw, mon_e.mem,
                   mon_e.ill);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; rs1_data = '0; rs2_data = '0;
    #2;
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    send(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7,
         mk("add", 32'd5, 32'd7, 4'b0010, 5'd3, 1'b1, 2'b00, 1'b0, 1'b1));
    chk("latency_out_valid", {31'b0, out_valid}, 32'd1);
    chk("latency_ctrl", {28'b0, alu_control}, 32'd2);

    send(enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd4), 32'hFFFF_FFFF, 32'd1,
         mk("slt", 32'h7FFF_FFFF, 32'h8000_0001, 4'b0101, 5'd4, 1'b1, 2'b00, 1'b0, 1'b1));
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd4), 32'hFFFF_FFFF, 32'd1,
         mk("sltu", 32'hFFFF_FFFF, 32'd1, 4'b0101, 5'd4, 1'b1, 2'b00, 1'b0, 1'b1));
    send(enc_i(12'h003, 5'd1, 3'b001, 5'd5, OPI), 32'h11, 32'h0,
         mk("slli", 32'h11, 32'd3, 4'b0001, 5'd5, 1'b1, 2'b00, 1'b0, 1'b1));
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd6), 32'h80, 32'h23,
         mk("sll", 32'h80, 32'd3, 4'b0001, 5'd6, 1'b1, 2'b00, 1'b0, 1'b1));
    send(enc_s(12'hFFC, 5'd2, 5'd1, 3'b010), 32'h100, 32'hDEAD,
         mk("sw", 32'h100, 32'hFFFF_FFFC, 4'b0010, 5'd0, 1'b0, 2'b10, 1'b0, 1'b1));
    send(enc_i(12'h008, 5'd1, 3'b010, 5'd7, OPL), 32'h200, 32'h0,
         mk("lw", 32'h200, 32'd8, 4'b0010, 5'd7, 1'b1, 2'b01, 1'b0, 1'b1));
    send(enc_r(7'h20, 5'd10, 5'd9, 3'b000, 5'd8), 32'd10, 32'd3,
         mk("sub", 32'd10, 32'd3, 4'b0100, 5'd8, 1'b1, 2'b00, 1'b0, 1'b1));
    send(enc_i(12'hFFF, 5'd1, 3'b100, 5'd9, OPI), 32'h0F0F, 32'h0,
         mk("xori", 32'h0F0F, 32'hFFFF_FFFF, 4'b0110, 5'd9, 1'b1, 2'b00, 1'b0, 1'b1));
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd10), 32'hF0, 32'hFF,
         mk("xor", 32'hF0, 32'hFF, 4'b0110, 5'd10, 1'b1, 2'b00, 1'b0, 1'b1));
    send(enc_i(12'hFFF, 5'd2, 3'b010, 5'd1, OPI), 32'h0, 32'h0,
         mk("slti", 32'h8000_0000, 32'h7FFF_FFFF, 4'b0101, 5'd1, 1'b1, 2'b00, 1'b0, 1'b1));
    send(enc_i(12'h001, 5'd3, 3'b011, 5'd2, OPI), 32'hFFFF_FFFF, 32'h0,
         mk("sltiu", 32'hFFFF_FFFF, 32'd1, 4'b0101, 5'd2, 1'b1, 2'b00, 1'b0, 1'b1));
    send(enc_i(12'h005, 5'd0, 3'b000, 5'd0, OPI), 32'h0, 32'h0,
         mk("addi_x0", 32'd0, 32'd5, 4'b0010, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1));
    send(enc_i(12'h403, 5'd1, 3'b001, 5'd5, OPI), 32'h11, 32'h0,
         mk("slli_bad_f7", 32'd0, 32'd0, 4'b0000, 5'd5, 1'b0, 2'b00, 1'b1, 1'b0));
    send(32'h0000_00FF, 32'h1, 32'h2,
         mk("opc_7f", 32'd0, 32'd0, 4'b0000, 5'd1, 1'b0, 2'b00, 1'b1, 1'b0));
    repeat (3) @(posedge clk); #1;
    chk("drain_directed", sbq.size(), 32'd0);

    // Backpressure: two entries fill the buffer, the third waits.
    out_ready = 1'b0;
    fork
      begin
        send(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd11), 32'd1, 32'h10,
             mk("skid0", 32'd1, 32'h10, 4'b0010, 5'd11, 1'b1, 2'b00, 1'b0, 1'b1));
        send(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd12), 32'd2, 32'h10,
             mk("skid1", 32'd2, 32'h10, 4'b0010, 5'd12, 1'b1, 2'b00, 1'b0, 1'b1));
        send(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd13), 32'd3, 32'h10,
             mk("skid2", 32'd3, 32'h10, 4'b0010, 5'd13, 1'b1, 2'b00, 1'b0, 1'b1));
      end
      begin
        repeat (2) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("skid_in_ready_low", {31'b0, in_ready}, 32'd0);
          chk("skid_out_valid", {31'b0, out_valid}, 32'd1);
          chk("skid_head_hold", alu_inp1, 32'd1);
          chk("skid_head_rd", {27'b0, rd_addr}, 32'd11);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;
    chk("drain_skid", sbq.size(), 32'd0);

    // Flush while full, with a new op presented in the same cycle.
    out_ready = 1'b0;
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd14), 32'd7, 32'd7,
         mk("fl0", 32'd7, 32'd7, 4'b0010, 5'd14, 1'b1, 2'b00, 1'b0, 1'b1));
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd15), 32'd8, 32'd8,
         mk("fl1", 32'd8, 32'd8, 4'b0010, 5'd15, 1'b1, 2'b00, 1'b0, 1'b1));
    chk("pre_flush_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b1; instr = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd16);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sbq.delete();
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd17), 32'hAA, 32'h55,
         mk("post_flush_xor", 32'hAA, 32'h55, 4'b0110, 5'd17, 1'b1, 2'b00, 1'b0, 1'b1));
    repeat (3) @(posedge clk); #1;
    chk("drain_flush", sbq.size(), 32'd0);

    // Asynchronous reset in the middle of a burst.
    out_ready = 1'b0;
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd18), 32'h33, 32'h44,
         mk("rst0", 32'h33, 32'h44, 4'b0010, 5'd18, 1'b1, 2'b00, 1'b0, 1'b1));
    send(enc_i(12'h004, 5'd1, 3'b010, 5'd19, OPL), 32'h55, 32'h0,
         mk("rst1", 32'h55, 32'd4, 4'b0010, 5'd19, 1'b1, 2'b01, 1'b0, 1'b1));
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd20), 32'h9, 32'h1,
         mk("post_rst_add", 32'h9, 32'h1, 4'b0010, 5'd20, 1'b1, 2'b00, 1'b0, 1'b1));
    repeat (3) @(posedge clk); #1;
    chk("drain_final", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
